// File: rtl/aes_pkg.sv
// aes_pkg: shared AES widths and the iterative-substitution FSM state encoding
package aes_pkg;
  localparam int AES_STATE_W = 128;
  localparam int AES_BYTE_W = 8;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2} aes_state_e;
endpackage

// File: rtl/inv_s_box.sv
// inv_s_box: 8-bit combinational AES inverse S-box lookup
module inv_s_box (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] INV_T = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};
  assign y = INV_T[{~a, 3'b000} +: 8];
endmodule

// File: rtl/s_box.sv
// s_box: 8-bit combinational AES forward S-box lookup
module s_box (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] FWD_T = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  assign y = FWD_T[{~a, 3'b000} +: 8];
endmodule

// File: rtl/inv_sub_bytes_iter.sv
// inv_sub_bytes_iter: iterative InvSubBytes over a 128-bit state, BYTES_PER_CYCLE bytes per cycle; AES_SBOX_MODE_EN adds a mode port selecting the forward S-box
module inv_sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] data_in,
`ifdef AES_SBOX_MODE_EN
  input  logic                   mode,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] data_out
);
  localparam int N = 16 / BYTES_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int LW = AES_BYTE_W * BYTES_PER_CYCLE;
  aes_state_e state;
  logic [CW-1:0] k;
  logic [AES_STATE_W-1:0] st, nxt;
  logic [LW-1:0] lane_o;
  int base;
`ifdef AES_SBOX_MODE_EN
  logic mode_q;
`endif
  assign data_out = st;
  assign base = int'(k) * BYTES_PER_CYCLE;
  for (genvar i = 0; i < BYTES_PER_CYCLE; i++) begin : g_lane
    logic [AES_BYTE_W-1:0] b, v;
    assign b = st[AES_STATE_W-1-AES_BYTE_W*(base+i) -: AES_BYTE_W];
    inv_s_box u_inv (.a(b), .y(v));
`ifdef AES_SBOX_MODE_EN
    logic [AES_BYTE_W-1:0] f;
    s_box u_fwd (.a(b), .y(f));
    assign lane_o[LW-1-AES_BYTE_W*i -: AES_BYTE_W] = mode_q ? f : v;
`else
    assign lane_o[LW-1-AES_BYTE_W*i -: AES_BYTE_W] = v;
`endif
  end
  // splice the substituted chunk back into its slot of the working state
  always_comb begin
    nxt = st;
    for (int j = 0; j < BYTES_PER_CYCLE; j++)
      nxt[AES_STATE_W-1-AES_BYTE_W*(base+j) -: AES_BYTE_W] = lane_o[LW-1-AES_BYTE_W*j -: AES_BYTE_W];
  end
  // control FSM with registered handshake outputs and the working register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      k <= '0;
      st <= '0;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
`ifdef AES_SBOX_MODE_EN
      mode_q <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          st <= data_in;
          k <= '0;
          state <= ST_BUSY;
          in_ready <= 1'b0;
`ifdef AES_SBOX_MODE_EN
          mode_q <= mode;
`endif
        end
        ST_BUSY: begin
          st <= nxt;
          k <= (k == CW'(N - 1)) ? '0 : k + 1'b1;
          if (k == CW'(N - 1)) begin
            state <= ST_DONE;
            out_valid <= 1'b1;
          end
        end
        ST_DONE: if (out_ready) begin
          state <= ST_IDLE;
          out_valid <= 1'b0;
          in_ready <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          in_ready <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// tb_inv_sub_bytes_iter: self-checking bench for inv_sub_bytes_iter against a GF(2^8) reference model
module tb_inv_sub_bytes_iter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, mode = 1'b0;
  logic [127:0] data_in = '0;
  logic in_ready, out_valid;
  logic [127:0] data_out;
  logic in_valid_s = 1'b0;
  logic [127:0] data_in_s = '0;
  logic ir_s [5];
  logic ov_s [5];
  logic [127:0] dq_s [5];
  logic [7:0] sb_a = '0, sb_y, rt_y;
  logic [7:0] fsb [256];
  logic [7:0] isb [256];
  int n_tests = 0, n_fail = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inv_sub_bytes_iter #(.BYTES_PER_CYCLE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
`ifdef AES_SBOX_MODE_EN
    .mode(mode),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out));

  for (genvar g = 0; g < 5; g++) begin : g_sw
    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(1 << g)) u_sw (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(ir_s[g]), .data_in(data_in_s),
`ifdef AES_SBOX_MODE_EN
      .mode(1'b0),
`endif
      .out_valid(ov_s[g]), .out_ready(1'b1), .data_out(dq_s[g]));
  end

  s_box u_ref_fwd (.a(sb_a), .y(sb_y));
  inv_s_box u_ref_inv (.a(sb_y), .y(rt_y));

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p = '0;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_model(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, x);
    return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] map_state(input logic [127:0] s, input bit fwd);
    logic [127:0] o;
    for (int j = 0; j < 16; j++)
      o[127-8*j -: 8] = fwd ? fsb[s[127-8*j -: 8]] : isb[s[127-8*j -: 8]];
    return o;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [127:0] din, input logic m, input bit tog, output int lat, output logic [127:0] dq);
    lat = 0;
    dq = '0;
    @(negedge clk);
    in_valid = 1'b1;
    data_in = din;
    mode = m;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) in_valid = 1'b0;
      if (tog && e == 2) mode = ~m;
      if (out_valid) begin
        lat = e;
        dq = data_out;
        break;
      end
    end
  endtask

  task automatic release_out(input string nm);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({nm, "_release"}, {in_ready, out_valid}, 2'b10);
    out_ready = 1'b0;
  endtask

  task automatic sweep(input logic [127:0] din);
    logic [127:0] e = map_state(din, 1'b0);
    int lat [5];
    logic [127:0] got [5];
    for (int g = 0; g < 5; g++) begin
      lat[g] = 0;
      got[g] = '0;
    end
    @(negedge clk);
    in_valid_s = 1'b1;
    data_in_s = din;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) in_valid_s = 1'b0;
      for (int g = 0; g < 5; g++)
        if (ov_s[g] && lat[g] == 0) begin
          lat[g] = c;
          got[g] = dq_s[g];
        end
    end
    for (int g = 0; g < 5; g++) begin
      chk($sformatf("sweep_lat_bpc%0d", 1 << g), 128'(lat[g]), 128'((16 >> g) + 1));
      chk($sformatf("sweep_data_bpc%0d", 1 << g), got[g], e);
      chk($sformatf("sweep_idle_bpc%0d", 1 << g), {127'd0, ir_s[g]}, 128'd1);
    end
  endtask

  typedef struct {
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;
  vec_t vt [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    logic [127:0] dq, hold, s;
    bit stable, leaked, found;
    int prev;
    for (int x = 0; x < 256; x++) fsb[x] = sbox_model(8'(x));
    for (int x = 0; x < 256; x++) isb[fsb[x]] = 8'(x);
    vt[0] = '{{16{8'h63}}, {16{8'h00}}};
    vt[1] = '{{16{8'h00}}, {16{8'h52}}};
    vt[2] = '{{4{32'h16ED7C63}}, {4{32'hFF530100}}};
    for (int i = 3; i < 6; i++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      vt[i] = '{s, map_state(s, 1'b0)};
    end

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {in_ready, out_valid, data_out}, {2'b10, 128'd0});
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_op(vt[i].din, 1'b0, 1'b0, lat, dq);
      chk($sformatf("vec%0d_latency", i), 128'(lat), 128'd5);
      chk($sformatf("vec%0d_data", i), dq, vt[i].exp);
      if (i == 0) begin
        stable = 1'b1;
        hold = dq;
        for (int c = 1; c <= 10; c++) begin
          @(negedge clk);
          in_valid = (c == 3);
          data_in = {4{32'hdeadbeef}};
          @(posedge clk);
          #1;
          if (out_valid !== 1'b1 || data_out !== hold || in_ready !== 1'b0) stable = 1'b0;
        end
        in_valid = 1'b0;
        chk("stall_stable", {127'd0, stable}, 128'd1);
      end
      release_out($sformatf("vec%0d", i));
    end

    @(negedge clk);
    in_valid = 1'b1;
    data_in = vt[3].din;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midbusy_reset", {in_ready, out_valid, data_out}, {2'b10, 128'd0});
    @(negedge clk);
    rst_n = 1'b1;
    leaked = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) leaked = 1'b1;
    end
    chk("reset_no_partial", {127'd0, leaked}, 128'd0);
    run_op(vt[4].din, 1'b0, 1'b0, lat, dq);
    chk("post_reset_latency", 128'(lat), 128'd5);
    chk("post_reset_data", dq, vt[4].exp);
    release_out("post_reset");

    for (int i = 0; i < 8; i++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      run_op(s, 1'b0, 1'b0, lat, dq);
      chk($sformatf("rand%0d_data", i), dq, map_state(s, 1'b0));
      release_out($sformatf("rand%0d", i));
    end

`ifdef AES_SBOX_MODE_EN
    run_op({16{8'h00}}, 1'b1, 1'b0, lat, dq);
    chk("mode_fwd_zero", dq, {16{8'h63}});
    release_out("mode_fwd_zero");
    s = {$urandom, $urandom, $urandom, $urandom};
    run_op(s, 1'b1, 1'b1, lat, dq);
    chk("mode_toggle_latency", 128'(lat), 128'd5);
    chk("mode_toggle_data", dq, map_state(s, 1'b1));
    release_out("mode_toggle");
    mode = 1'b0;
`endif

    sweep({16{8'h00}});
    sweep({4{32'h16ED7C63}});

    for (int x = 0; x < 256; x++) begin
      sb_a = 8'(x);
      #1;
      chk($sformatf("sbox_roundtrip_%0d", x), {112'd0, sb_y, rt_y}, {112'd0, fsb[x], 8'(x)});
    end

    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int j = 0; j < 16; j++) data_in[127-8*j -: 8] = fsb[j];
    prev = -1;
    for (int op = 0; op < 16; op++) begin
      found = 1'b0;
      for (int w = 0; w < 20; w++) begin
        @(posedge clk);
        #1;
        if (out_valid) begin
          found = 1'b1;
          break;
        end
      end
      chk($sformatf("b2b%0d_found", op), {127'd0, found}, 128'd1);
      for (int j = 0; j < 16; j++) s[127-8*j -: 8] = 8'(16 * op + j);
      chk($sformatf("b2b%0d_data", op), data_out, s);
      if (op > 0) chk($sformatf("b2b%0d_period", op), 128'(cyc - prev), 128'd6);
      prev = cyc;
      @(negedge clk);
      if (op < 15) for (int j = 0; j < 16; j++) data_in[127-8*j -: 8] = fsb[16 * (op + 1) + j];
      else in_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("b2b_final_idle", {in_ready, out_valid}, 2'b10);
    out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/inv_sub_bytes_iter.md
INV_SUB_BYTES_ITER -- requirements
Module: inv_sub_bytes_iter

Interface
REQ-001 SHALL have parameter BYTES_PER_CYCLE, default 4, meaning bytes substituted per BUSY cycle; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: data_in is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept a state.
REQ-006 SHALL have port data_in, input, 128 bits: cipher state; byte 0 is bits 127:120.
REQ-007 SHALL have port out_valid, output, 1 bit: data_out holds a result.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer accepts data_out.
REQ-009 SHALL have port data_out, output, 128 bits: InvSubBytes(data_in), same byte ordering.

Function
REQ-010 SHALL implement a three-state FSM (IDLE, BUSY, DONE); in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-011 SHALL, in IDLE with in_valid=1 at a clock edge, capture data_in into the working register, clear the chunk counter and enter BUSY.
REQ-012 SHALL, in each BUSY cycle, replace chunk k (bytes k*BPC .. k*BPC+BPC-1, MSB first) with its inverse S-box image, then increment k.
REQ-013 SHALL leave BUSY for DONE on the edge that writes the last chunk (k = 16/BPC-1); N = 16/BPC BUSY cycles.
REQ-014 SHALL assert out_valid exactly N+1 edges after the accepting edge (default: 5).
REQ-015 SHALL hold data_out and out_valid stable in DONE while out_ready=0.
REQ-016 SHALL return to IDLE on the edge where out_valid and out_ready are both 1; no new state is accepted on that edge.
REQ-017 SHALL ignore in_valid outside IDLE and ignore out_ready outside DONE.
REQ-018 SHALL drive data_out from the working register at all times; contents outside DONE are don't-care for consumers.
REQ-019 SHALL wrap the chunk counter to 0 on entry to BUSY; the counter is ceil(log2(16/BPC)) bits, minimum 1.

Reset
REQ-020 SHALL, on rst_n=0 at any time including mid-BUSY, asynchronously force FSM=IDLE, counter=0, working register=0, in_ready=1, out_valid=0, data_out=0.
REQ-021 SHALL abandon any in-flight state on reset with no partial output.

Configuration
REQ-022 SHALL support the macro AES_SBOX_MODE_EN.
REQ-023 SHALL, with AES_SBOX_MODE_EN defined, add input port mode (1 bit), sampled with data_in at accept: 0 selects inverse S-box, 1 selects forward S-box, and the selection holds for the whole operation.
REQ-024 SHALL, without AES_SBOX_MODE_EN, omit the mode port and perform the inverse S-box only; timing is identical in both builds.

Structure
REQ-025 SHALL take from shared package aes_pkg: AES_STATE_W=128, AES_BYTE_W=8, and the FSM state typedef/encoding.
REQ-026 SHALL instantiate BYTES_PER_CYCLE copies of sub-module inv_s_box (8-bit combinational inverse S-box); with AES_SBOX_MODE_EN, each lane also instantiates the existing forward s_box and selects between the two outputs with a mux.

Verification
REQ-027 SHALL cover all-0x63 input -> all-0x00 output, out_valid at accept+5, BPC=4.
REQ-028 SHALL cover all-0x00 input -> all-0x52, and input 0x16ED7C63 repeated -> 0xFF530100 repeated, each for BPC=1, 2, 4, 8 and 16, with latency 17, 9, 5, 3 and 2 edges respectively.
REQ-029 SHALL cover out_ready held low 10 cycles after out_valid -> data_out and out_valid stable, in_ready=0, and a new in_valid ignored.
REQ-030 SHALL cover rst_n pulsed low in the 2nd BUSY cycle -> immediate out_valid=0, data_out=0, in_ready=1, and the next operation correct.
REQ-031 SHALL cover, with AES_SBOX_MODE_EN and mode=1, input all-0x00 -> all-0x63, and mode toggled mid-BUSY having no effect.
REQ-032 SHALL cover back-to-back operations with in_valid and out_ready tied high -> one result every N+2 cycles, and all 256 byte values round-trip through the forward s_box to the identity.
